// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - valid/allowin/bus handshake between adjacent pipeline stages
interface mem_stage_if #(
    parameter int WD = 32
);
    logic          valid;
    logic          allowin;
    logic [WD-1:0] bus;

    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: load-data wait/align, es->ms receiver, ms->ws sender
// Optional MEM->decode bypass ports (ms_fwd_valid/ms_fwd_data) exist when MS_FWD_EN is defined.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  es_ms,
    mem_stage_if.master ms_ws,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_valid,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_blocking
`ifdef MS_FWD_EN
   ,output logic        ms_fwd_valid,
    output logic [31:0] ms_fwd_data
`endif
);
    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 70;

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                buf_q, buf_d;

    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_waddr;
    logic [31:0] alu_res;
    logic        is_load;
    logic [2:0]  ld_op;
    logic        req_sent;

    assign {ms_pc, ms_rf_we, ms_waddr, alu_res, is_load, ld_op, req_sent} = es_bus_q;

    logic        need_data;
    logic        ready_go;
    logic        ms_allowin;
    logic        ms_handshake;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] rf_wdata;

    assign need_data    = is_load & req_sent;
    assign ready_go     = !need_data | data_sram_data_ok | buf_valid_q;
    assign ms_allowin   = !ms_valid_q | (ready_go & ms_ws.allowin);
    assign ms_handshake = ms_valid_q & ready_go & ms_ws.allowin;

    assign es_ms.allowin = ms_allowin;
    assign ms_ws.valid   = ms_valid_q & ready_go;
    assign ms_ws.bus     = {ms_pc, ms_rf_we, ms_waddr, rf_wdata};

    assign ms_valid    = ms_valid_q;
    assign ms_rf_waddr = ms_waddr;
    assign ms_blocking = ms_valid_q & need_data & !ready_go;

    // Once buffered, the held word wins over whatever the SRAM bus shows now.
    assign ld_word = buf_valid_q ? buf_q : data_sram_rdata;
    assign ld_byte = ld_word[8*alu_res[1:0] +: 8];
    assign ld_half = ld_word[16*alu_res[1] +: 16];

    always_comb begin
        ld_data = ld_word;
        case (ld_op)
            3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_data = {24'd0, ld_byte};
            3'b011:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    assign rf_wdata = is_load ? ld_data : alu_res;

`ifdef MS_FWD_EN
    assign ms_fwd_valid = ms_valid_q & ms_rf_we & ready_go;
    assign ms_fwd_data  = rf_wdata;
`endif

    always_comb begin
        ms_valid_d  = ms_allowin ? es_ms.valid : ms_valid_q;
        es_bus_d    = (ms_allowin & es_ms.valid) ? es_ms.bus : es_bus_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        // Capture only when the data arrives but WB cannot take it this cycle.
        if (ms_handshake) begin
            buf_valid_d = 1'b0;
        end else if (data_sram_data_ok & ms_valid_q & need_data & !buf_valid_q & !ms_ws.allowin) begin
            buf_valid_d = 1'b1;
            buf_d       = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_q  <= 1'b0;
            es_bus_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            es_bus_q    <= es_bus_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized checks of mem_stage against a transaction model
module tb_mem_stage;
    localparam int N = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ok;
    logic [31:0] rdata;
    logic        ms_valid;
    logic [4:0]  ms_rf_waddr;
    logic        ms_blocking;
`ifdef MS_FWD_EN
    logic        ms_fwd_valid;
    logic [31:0] ms_fwd_data;
`endif

    mem_stage_if #(.WD(75)) es_ms ();
    mem_stage_if #(.WD(70)) ms_ws ();

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_ms             (es_ms),
        .ms_ws             (ms_ws),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_valid          (ms_valid),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_blocking       (ms_blocking)
`ifdef MS_FWD_EN
       ,.ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_data       (ms_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic        ld;
        logic [2:0]  op;
    } ins_t;

    ins_t ins [N];

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [74:0] mk_bus(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                           input logic [31:0] alu, input logic ld, input logic [2:0] op,
                                           input logic req);
        return {pc, we, wa, alu, ld, op, req};
    endfunction

    function automatic logic [69:0] wb_bus(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        return {pc, we, wa, wd};
    endfunction

    // Load result from the ISA rules: shift the addressed lane down, then extend.
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    initial begin
        int          sent, done, occ_idx;
        logic        occ, got, exp_rdy, exp_allow;
        logic [31:0] occ_word, exp_wd;

        reset         = 1'b0;
        data_ok       = 1'b0;
        rdata         = '0;
        es_ms.valid   = 1'b0;
        es_ms.bus     = '0;
        ms_ws.allowin = 1'b0;
        #2;
        check("rst_ms_valid", ms_valid, 1'b0);
        check("rst_to_ws_valid", ms_ws.valid, 1'b0);
        check("rst_blocking", ms_blocking, 1'b0);
        check("rst_allowin", es_ms.allowin, 1'b1);
        step();
        step();
        reset = 1'b1;

        // addu: zero added latency
        es_ms.valid   = 1'b1;
        es_ms.bus     = mk_bus(32'hBFC00000, 1'b1, 5'd3, 32'h12, 1'b0, 3'd0, 1'b0);
        ms_ws.allowin = 1'b1;
        #1 check("addu_accept", es_ms.allowin, 1'b1);
        step();
        es_ms.valid = 1'b0;
        #1;
        check("addu_valid", ms_ws.valid, 1'b1);
        check("addu_bus", ms_ws.bus, wb_bus(32'hBFC00000, 1'b1, 5'd3, 32'h12));
        step();
        #1 check("addu_gone", ms_valid, 1'b0);

        // lb off=3, data two cycles late
        es_ms.valid = 1'b1;
        es_ms.bus   = mk_bus(32'hBFC00004, 1'b1, 5'd4, 32'h1003, 1'b1, 3'd1, 1'b1);
        step();
        es_ms.valid = 1'b0;
        #1;
        check("lb_block0", ms_blocking, 1'b1);
        check("lb_wait0", ms_ws.valid, 1'b0);
        step();
        #1 check("lb_block1", ms_blocking, 1'b1);
        step();
        data_ok = 1'b1;
        rdata   = 32'h80FF1234;
        #1;
        check("lb_valid", ms_ws.valid, 1'b1);
        check("lb_bus", ms_ws.bus, wb_bus(32'hBFC00004, 1'b1, 5'd4, 32'hFFFFFF80));
        check("lb_unblock", ms_blocking, 1'b0);
        step();
        data_ok = 1'b0;
        #1 check("lb_gone", ms_valid, 1'b0);

        // lhu off=2, WB stalled at data_ok -> buffered
        es_ms.valid = 1'b1;
        es_ms.bus   = mk_bus(32'hBFC00008, 1'b1, 5'd5, 32'h2002, 1'b1, 3'd4, 1'b1);
        step();
        es_ms.valid   = 1'b0;
        data_ok       = 1'b1;
        rdata         = 32'h8001ABCD;
        ms_ws.allowin = 1'b0;
        #1;
        check("lhu_ready", ms_ws.valid, 1'b1);
        check("lhu_stall_allowin", es_ms.allowin, 1'b0);
        step();
        data_ok = 1'b0;
        rdata   = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lhu_held_valid", ms_ws.valid, 1'b1);
            check("lhu_held_bus", ms_ws.bus, wb_bus(32'hBFC00008, 1'b1, 5'd5, 32'h00008001));
            step();
        end
        ms_ws.allowin = 1'b1;
        #1 check("lhu_bus", ms_ws.bus, wb_bus(32'hBFC00008, 1'b1, 5'd5, 32'h00008001));
        step();
        #1 check("lhu_gone", ms_valid, 1'b0);

        // lw with bypass observation
        es_ms.valid = 1'b1;
        es_ms.bus   = mk_bus(32'hBFC0000C, 1'b1, 5'd6, 32'h100, 1'b1, 3'd0, 1'b1);
        step();
        es_ms.valid = 1'b0;
`ifdef MS_FWD_EN
        #1 check("fwd_wait", ms_fwd_valid, 1'b0);
`endif
        step();
        data_ok = 1'b1;
        rdata   = 32'hDEADBEEF;
        #1;
        check("lw_bus", ms_ws.bus, wb_bus(32'hBFC0000C, 1'b1, 5'd6, 32'hDEADBEEF));
`ifdef MS_FWD_EN
        check("fwd_valid", ms_fwd_valid, 1'b1);
        check("fwd_data", ms_fwd_data, 32'hDEADBEEF);
`endif
        step();
        data_ok = 1'b0;

        // reset while a lw waits, late data_ok afterwards
        es_ms.valid = 1'b1;
        es_ms.bus   = mk_bus(32'hBFC00010, 1'b1, 5'd7, 32'h200, 1'b1, 3'd0, 1'b1);
        step();
        es_ms.valid = 1'b0;
        #1 check("rstw_block", ms_blocking, 1'b1);
        reset = 1'b0;
        #1;
        check("rstw_ms_valid", ms_valid, 1'b0);
        check("rstw_to_ws", ms_ws.valid, 1'b0);
        check("rstw_allowin", es_ms.allowin, 1'b1);
        step();
        reset = 1'b1;
        step();
        data_ok = 1'b1;
        rdata   = 32'h13572468;
        #1;
        check("late_ok_to_ws", ms_ws.valid, 1'b0);
        check("late_ok_allowin", es_ms.allowin, 1'b1);
        step();
        data_ok = 1'b0;
        #1 check("late_ok_after", ms_ws.valid, 1'b0);

        // randomized stream against the transaction model
        for (int i = 0; i < N; i++) begin
            ins[i].pc  = 32'hBFC01000 + 32'(4 * i);
            ins[i].we  = ($urandom % 4) != 0;
            ins[i].wa  = 5'($urandom);
            ins[i].ld  = ($urandom % 2) != 0;
            ins[i].op  = 3'($urandom);
            ins[i].alu = $urandom;
            if (ins[i].ld) begin
                if (ins[i].op == 3'd3 || ins[i].op == 3'd4) ins[i].alu[0] = 1'b0;
                else if (ins[i].op != 3'd1 && ins[i].op != 3'd2) ins[i].alu[1:0] = 2'b00;
            end
        end
        sent = 0; done = 0; occ_idx = 0;
        occ = 1'b0; got = 1'b0; occ_word = '0;
        for (int cyc = 0; cyc < 3000 && done < N; cyc++) begin
            es_ms.valid   = (sent < N) && (($urandom % 4) != 0);
            es_ms.bus     = (sent < N) ? mk_bus(ins[sent].pc, ins[sent].we, ins[sent].wa, ins[sent].alu,
                                                ins[sent].ld, ins[sent].op, ins[sent].ld) : '0;
            ms_ws.allowin = ($urandom % 3) != 0;
            data_ok       = 1'b0;
            rdata         = $urandom;
            if (occ && ins[occ_idx].ld && !got && ($urandom % 2) == 0) begin
                data_ok  = 1'b1;
                got      = 1'b1;
                occ_word = rdata;
            end
            #1;
            exp_rdy   = occ && (!ins[occ_idx].ld || got);
            exp_allow = !occ || (exp_rdy && ms_ws.allowin);
            exp_wd    = ins[occ_idx].ld ? exp_load(ins[occ_idx].op, ins[occ_idx].alu[1:0], occ_word)
                                        : ins[occ_idx].alu;
            check("rnd_to_ws_valid", ms_ws.valid, exp_rdy);
            check("rnd_allowin", es_ms.allowin, exp_allow);
            check("rnd_blocking", ms_blocking, occ && ins[occ_idx].ld && !got);
            check("rnd_ms_valid", ms_valid, occ);
            if (occ) check("rnd_waddr", ms_rf_waddr, ins[occ_idx].wa);
`ifdef MS_FWD_EN
            check("rnd_fwd_valid", ms_fwd_valid, exp_rdy && ins[occ_idx].we);
            if (exp_rdy) check("rnd_fwd_data", ms_fwd_data, exp_wd);
`endif
            if (exp_rdy && ms_ws.allowin) begin
                check("rnd_bus", ms_ws.bus, wb_bus(ins[occ_idx].pc, ins[occ_idx].we, ins[occ_idx].wa, exp_wd));
                done++;
                occ = 1'b0;
            end
            if (es_ms.valid && exp_allow) begin
                occ     = 1'b1;
                occ_idx = sent;
                got     = 1'b0;
                sent++;
            end
            step();
        end
        check("rnd_all_retired", 70'(done), 70'(N));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
